block_interleaver_pp: RTL and testbench

//  Parametrised row/column block (de)interleaver; next generation of the 1-bit interleaver.

---
 rtl/block_interleaver_pp.sv | 137 +++++++++++++
 tb/tb_block_interleaver_pp.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_interleaver_pp.sv
// Ping-pong row/column block (de)interleaver with valid/ready on both sides.
// One bank fills while the other drains; addresses come from wrap counters.
module block_interleaver_pp #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2((ROWS > COLS) ? ROWS : COLS);

  localparam logic [AW-1:0] K_LAST  = AW'(N - 1);
  localparam logic [AW-1:0] ROWS_A  = AW'(ROWS);
  localparam logic [AW-1:0] COLS_A  = AW'(COLS);
  localparam logic [CW-1:0] ROWS_M1 = CW'(ROWS - 1);
  localparam logic [CW-1:0] COLS_M1 = CW'(COLS - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  bank_state_t      state      [2];
  bank_state_t      state_next [2];
  logic             wb, rb;
  logic [AW-1:0]    wk, rk, raddr;
  logic [CW-1:0]    inner, outer;
  logic [1:0]       bank_mode;
  logic [WIDTH-1:0] mem [2**(AW+1)];
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, rd_last;

  logic             wr_fire, wr_last, rd_issue, rd_last_issue;
  logic             out_adv, s1_adv, rd_mode;
  logic [CW-1:0]    inner_m1;
  logic [AW-1:0]    stride;

  // Bank state register
  always_ff @(posedge clk2) begin
    if (rst) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
    end else begin
      state[0] <= state_next[0];
      state[1] <= state_next[1];
    end
  end

  // A bank is released as soon as its last address has been read from RAM;
  // the symbol is already in the pipeline, so the writer may refill at once.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) state_next[b] = state[b];
    if (wr_fire) state_next[wb] = wr_last ? FULL : FILLING;
    if (rd_issue) state_next[rb] = rd_last_issue ? EMPTY : DRAINING;
  end

  always_comb begin
    din_ready     = !rst && (state[wb] == EMPTY || state[wb] == FILLING);
    wr_fire       = din_valid && din_ready;
    wr_last       = wr_fire && (wk == K_LAST);
    out_adv       = !dout_valid || dout_ready;
    s1_adv        = !rd_valid || out_adv;
    rd_issue      = s1_adv && (state[rb] == FULL || state[rb] == DRAINING);
    rd_last_issue = rd_issue && (rk == K_LAST);
    rd_mode       = bank_mode[rb];
    inner_m1      = rd_mode ? COLS_M1 : ROWS_M1;
    stride        = rd_mode ? ROWS_A : COLS_A;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      wb         <= 1'b0;
      rb         <= 1'b0;
      wk         <= '0;
      rk         <= '0;
      raddr      <= '0;
      inner      <= '0;
      outer      <= '0;
      bank_mode  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wk <= wr_last ? '0 : wk + 1'b1;
        if (wr_last) wb <= ~wb;
        if (wk == '0) bank_mode[wb] <= mode;
      end
      // Inner counter strides through one column (or row); wrap starts the next one
      if (rd_issue) begin
        if (rd_last_issue) begin
          rk    <= '0;
          raddr <= '0;
          inner <= '0;
          outer <= '0;
          rb    <= ~rb;
        end else begin
          rk <= rk + 1'b1;
          if (inner == inner_m1) begin
            inner <= '0;
            outer <= outer + 1'b1;
            raddr <= AW'(outer) + 1'b1;
          end else begin
            inner <= inner + 1'b1;
            raddr <= raddr + stride;
          end
        end
      end
      if (s1_adv) begin
        rd_valid <= rd_issue;
        rd_last  <= rd_last_issue;
      end
      if (out_adv) begin
        dout_valid <= rd_valid;
        dout_last  <= rd_valid && rd_last;
        if (rd_valid) dout <= rd_data;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (wr_fire) mem[{wb, wk}] <= din;
    if (rd_issue) rd_data <= mem[{rb, raddr}];
  end

endmodule

// File: tb/tb_block_interleaver_pp.sv
// Bench for block_interleaver_pp: directed scenarios plus randomized traffic
// checked against a frame-level reference built from the index formulas.
module tb_block_interleaver_pp;

  localparam int R = 4;
  localparam int C = 4;
  localparam int N = R * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, mode, din_valid, din_ready, dout_valid, dout_ready, dout_last;
  logic [7:0] din, dout;
  logic       s_mode, s_din_valid, s_din_ready, s_dout_valid, s_dout_ready, s_dout_last;
  logic [7:0] s_din, s_dout;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int first_valid;
  int stalls;

  logic [7:0] in_sym  [$];
  logic       in_mode [$];
  logic [8:0] out_q   [$];
  logic [8:0] exp_q   [$];
  int         out_cyc [$];

  block_interleaver_pp #(.WIDTH(8), .ROWS(4), .COLS(4)) dut (
    .clk2(clk), .rst(rst), .mode(mode), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last)
  );

  block_interleaver_pp #(.WIDTH(8), .ROWS(2), .COLS(3)) dut23 (
    .clk2(clk), .rst(rst), .mode(s_mode), .din(s_din), .din_valid(s_din_valid),
    .din_ready(s_din_ready), .dout(s_dout), .dout_valid(s_dout_valid),
    .dout_ready(s_dout_ready), .dout_last(s_dout_last)
  );

  // Drive one cycle of stimulus on the 4x4 instance and record the transfers.
  task automatic tick(input logic dv, input logic [7:0] d, input logic m, input logic dr);
    @(negedge clk);
    din_valid  = dv;
    din        = d;
    mode       = m;
    dout_ready = dr;
    #1;
    cyc++;
    if (din_valid && !din_ready) stalls++;
    if (din_valid && din_ready) begin
      in_sym.push_back(din);
      in_mode.push_back(mode);
    end
    if (dout_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (dout_ready) begin
        out_q.push_back({dout_last, dout});
        out_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic drain(input int target, input int budget, input bit rnd);
    for (int i = 0; i < budget && out_q.size() < target; i++)
      tick(1'b0, 8'h00, 1'b0, rnd ? 1'($urandom_range(1)) : 1'b1);
  endtask

  task automatic clear_model();
    in_sym.delete();
    in_mode.delete();
    out_q.delete();
    exp_q.delete();
    out_cyc.delete();
    stalls      = 0;
    first_valid = -1;
  endtask

  // Reference: each complete frame permuted by its first symbol's mode.
  task automatic build_expected();
    int idx;
    exp_q.delete();
    for (int f = 0; f < in_sym.size() / N; f++) begin
      for (int k = 0; k < N; k++) begin
        if (in_mode[f*N]) idx = (k % C) * R + k / C;
        else              idx = (k % R) * C + k / R;
        exp_q.push_back({k == N - 1, in_sym[f*N + idx]});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0; din = '0; mode = 1'b0; dout_ready = 1'b1;
    s_din_valid = 1'b0; s_din = '0; s_mode = 1'b0; s_dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (din_ready !== 1'b0 || s_din_ready !== 1'b0) begin
      errors++; $display("FAIL reset_din_ready: got %b/%b expected 0/0", din_ready, s_din_ready);
    end
    vectors++;
    if ({dout_valid, dout_last, dout} !== 10'h000) begin
      errors++; $display("FAIL reset_outputs: got valid=%b last=%b dout=%0d expected 0 0 0", dout_valid, dout_last, dout);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (din_ready !== 1'b1 || s_din_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", din_ready, s_din_ready);
    end
  endtask

  task automatic test_basic();
    int t1_exp [16];
    int accept_cyc;
    t1_exp = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    clear_model();
    for (int k = 0; k < N; k++) tick(1'b1, 8'(k), 1'b0, 1'b1);
    accept_cyc = cyc;
    drain(N, 100, 1'b0);
    vectors++;
    if (out_q.size() != N) begin
      errors++; $display("FAIL t1_count: got %0d expected %0d", out_q.size(), N);
    end
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== {i == N - 1, 8'(t1_exp[i])}) begin
        errors++; $display("FAIL t1_sym[%0d]: got last=%b d=%0d expected last=%b d=%0d",
                           i, out_q[i][8], out_q[i][7:0], i == N - 1, t1_exp[i]);
      end
    end
    // Write edge at end of accept cycle, RAM read edge, output register edge.
    vectors++;
    if (first_valid - accept_cyc != 3) begin
      errors++; $display("FAIL t1_latency: got %0d expected 3 sampled cycles", first_valid - accept_cyc);
    end
  endtask

  task automatic test_small_geometry();
    logic [7:0] src  [12];
    logic [7:0] want [12];
    logic [8:0] got  [$];
    int idx;
    src  = '{0, 1, 2, 3, 4, 5, 0, 3, 1, 4, 2, 5};
    want = '{0, 3, 1, 4, 2, 5, 0, 1, 2, 3, 4, 5};
    idx  = 0;
    for (int c = 0; c < 80 && got.size() < 12; c++) begin
      @(negedge clk);
      if (idx < 12) begin
        s_din_valid = 1'b1; s_din = src[idx]; s_mode = (idx >= 6);
      end else begin
        s_din_valid = 1'b0;
      end
      s_dout_ready = 1'b1;
      #1;
      if (s_din_valid && s_din_ready) idx++;
      if (s_dout_valid && s_dout_ready) got.push_back({s_dout_last, s_dout});
    end
    s_din_valid = 1'b0;
    vectors++;
    if (got.size() != 12) begin
      errors++; $display("FAIL t2_count: got %0d expected 12", got.size());
    end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== {(i == 5 || i == 11), want[i]}) begin
        errors++; $display("FAIL t2_sym[%0d]: got last=%b d=%0d expected last=%b d=%0d",
                           i, got[i][8], got[i][7:0], (i == 5 || i == 11), want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < N; k++) tick(1'b1, 8'($urandom_range(255)), 1'(f % 2), 1'b1);
    vectors++;
    if (stalls != 0 || in_sym.size() != 4 * N) begin
      errors++; $display("FAIL t3_input_stall: got stalls=%0d accepted=%0d expected 0 and %0d", stalls, in_sym.size(), 4 * N);
    end
    drain(4 * N, 200, 1'b0);
    build_expected();
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t3_count: got %0d expected %0d", out_q.size(), exp_q.size());
    end else begin
      vectors++;
      if (out_cyc[4*N-1] - out_cyc[0] != 4 * N - 1) begin
        errors++; $display("FAIL t3_output_gaps: got span %0d expected %0d", out_cyc[4*N-1] - out_cyc[0], 4 * N - 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t3_sym[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] held;
    bit have;
    have = 1'b0;
    held = '0;
    clear_model();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(in_sym.size()), 1'b0, 1'b0);
      if (dout_valid) begin
        if (!have) begin
          held = {dout_last, dout};
          have = 1'b1;
        end else begin
          vectors++;
          if ({dout_last, dout} !== held) begin
            errors++; $display("FAIL t4_hold: got %h expected %h", {dout_last, dout}, held);
          end
        end
      end
    end
    vectors++;
    if (!have) begin
      errors++; $display("FAIL t4_valid_while_stalled: got dout_valid=0 expected 1");
    end
    vectors++;
    if (in_sym.size() != 2 * N || din_ready !== 1'b0) begin
      errors++; $display("FAIL t4_accept_limit: got accepted=%0d din_ready=%b expected %0d and 0", in_sym.size(), din_ready, 2 * N);
    end
    drain(2 * N, 200, 1'b0);
    build_expected();
    vectors++;
    if (out_q.size() != exp_q.size() || out_q.size() == 0) begin
      errors++; $display("FAIL t4_count: got %0d expected %0d", out_q.size(), exp_q.size());
    end else begin
      vectors++;
      if (out_q[0] !== held) begin
        errors++; $display("FAIL t4_resume_first: got %h expected held %h", out_q[0], held);
      end
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t4_sym[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    clear_model();
    for (int i = 0; i < 40000 && in_sym.size() < 200 * N; i++)
      tick(1'($urandom_range(1)), 8'($urandom_range(255)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    drain(200 * N, 8000, 1'b1);
    build_expected();
    vectors++;
    if (out_q.size() != exp_q.size() || exp_q.size() != 200 * N) begin
      errors++; $display("FAIL t5_count: got %0d outputs, %0d expected, %0d inputs", out_q.size(), exp_q.size(), in_sym.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t5_sym[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_model();
    for (int k = 0; k < N; k++) tick(1'b1, 8'(k + 100), 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b1, 8'(k + 200), 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    #1;
    vectors++;
    if (din_ready !== 1'b0) begin
      errors++; $display("FAIL t6_ready_in_reset: got %b expected 0", din_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL t6_flush: got valid=%b dout=%0d expected 0 0", dout_valid, dout);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (din_ready !== 1'b1) begin
      errors++; $display("FAIL t6_ready_after: got %b expected 1", din_ready);
    end
    clear_model();
    drain(1, 10, 1'b0);
    for (int k = 0; k < N; k++) tick(1'b1, 8'(k), 1'b0, 1'b1);
    drain(N, 100, 1'b0);
    build_expected();
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL t6_count: got %0d expected %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL t6_sym[%0d]: got %h expected %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    first_valid = -1;
    stalls      = 0;
    test_reset();
    test_basic();
    test_small_geometry();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
